// File: rtl/uart_rx_word.sv
// UART receiver (8N1) with a majority-vote line filter, frame-error detection,
// idle-line detection and pairing of consecutive bytes into 16-bit words.
// The first byte of a pair is the low half of RxD_word.
module uart_rx_word #(
  parameter int ClkFrequency = 25000000,
  parameter int Baud         = 115200,
  parameter int Oversampling = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RxD,
  output logic        RxD_data_ready,
  output logic [7:0]  RxD_data,
  output logic        RxD_word_ready,
  output logic [15:0] RxD_word,
  output logic        RxD_frame_err,
  output logic        RxD_idle
);

  // Phase accumulator: one extra bit holds the carry, so an increment of
  // exactly 2^AccW (tick rate == clock rate) still fits and ticks every clk.
  localparam int AccW = 24;
  localparam longint unsigned IncL =
    ((longint'(Baud) * longint'(Oversampling)) << AccW) / longint'(ClkFrequency);
  localparam logic [AccW:0] Inc = IncL[AccW:0];

  localparam int CntW = $clog2(Oversampling);
  localparam logic [CntW-1:0] CntLast = CntW'(Oversampling - 1);
  localparam logic [CntW-1:0] CntHalf = CntW'(Oversampling / 2 - 1);

  localparam int IdleTicks = 10 * Oversampling;
  localparam int IdleW     = $clog2(IdleTicks + 1);
  localparam logic [IdleW-1:0] IdleMax = IdleW'(IdleTicks);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

  logic [AccW-1:0]  r_acc;
  logic [AccW:0]    w_acc_sum;
  logic             w_tick;
  logic [1:0]       r_sync;
  logic [1:0]       r_samp;
  logic             r_filt;
  logic             w_maj;

  state_t           r_state;
  logic [CntW-1:0]  r_cnt;
  logic [2:0]       r_bit;
  logic [7:0]       r_shift;
  logic [IdleW-1:0] r_idle_cnt;
  logic             r_phase;
  logic [7:0]       r_low;
  logic [7:0]       r_data;
  logic [15:0]      r_word;
  logic             r_data_ready;
  logic             r_word_ready;
  logic             r_frame_err;
  logic             r_idle;

  assign w_acc_sum = {1'b0, r_acc} + Inc;
  assign w_tick    = w_acc_sum[AccW];

  // Free-running baud*oversampling tick generator
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_acc <= '0;
    else        r_acc <= w_acc_sum[AccW-1:0];
  end

  // Two-flop synchronizer for the asynchronous serial line (idle high)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sync <= 2'b11;
    else        r_sync <= {r_sync[0], RxD};
  end

  // Majority of the current synchronized sample and the two before it
  assign w_maj = (r_samp[1] & r_samp[0]) | (r_samp[1] & r_sync[1]) | (r_samp[0] & r_sync[1]);

  // Glitch filter, advanced only on oversample ticks
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_samp <= 2'b11;
      r_filt <= 1'b1;
    end else if (w_tick) begin
      r_samp <= {r_samp[0], r_sync[1]};
      r_filt <= w_maj;
    end
  end

  // Receive FSM with byte/word assembly, idle tracking and registered pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_bit        <= '0;
      r_shift      <= '0;
      r_idle_cnt   <= '0;
      r_phase      <= 1'b0;
      r_low        <= '0;
      r_data       <= '0;
      r_word       <= '0;
      r_data_ready <= 1'b0;
      r_word_ready <= 1'b0;
      r_frame_err  <= 1'b0;
      r_idle       <= 1'b0;
    end else begin
      r_data_ready <= 1'b0;
      r_word_ready <= 1'b0;
      r_frame_err  <= 1'b0;
      if (w_tick) begin
        // any low sample restarts the idle measurement
        if (!r_filt) r_idle_cnt <= '0;
        case (r_state)
          S_IDLE: begin
            if (!r_filt) begin
              r_state <= S_START;
              r_cnt   <= '0;
              r_idle  <= 1'b0;
            end else if (r_idle_cnt != IdleMax) begin
              r_idle_cnt <= r_idle_cnt + 1'b1;
              // long silence: a lone pending low byte no longer pairs up
              if (r_idle_cnt == IdleMax - 1'b1) begin
                r_idle  <= 1'b1;
                r_phase <= 1'b0;
              end
            end
          end
          S_START: begin
            if (r_cnt == CntHalf) begin
              if (r_filt) begin
                r_state <= S_IDLE;          // too short to be a start bit
              end else begin
                r_state <= S_DATA;
                r_cnt   <= '0;
                r_bit   <= '0;
              end
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          S_DATA: begin
            if (r_cnt == CntLast) begin
              r_cnt   <= '0;
              r_shift <= {r_filt, r_shift[7:1]};   // LSB first
              r_bit   <= r_bit + 1'b1;
              if (r_bit == 3'd7) r_state <= S_STOP;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          S_STOP: begin
            if (r_cnt == CntLast) begin
              r_cnt <= '0;
              if (r_filt) begin
                r_state      <= S_IDLE;
                r_data       <= r_shift;
                r_data_ready <= 1'b1;
                if (r_phase) begin
                  r_word       <= {r_shift, r_low};
                  r_word_ready <= 1'b1;
                  r_phase      <= 1'b0;
                end else begin
                  r_low   <= r_shift;
                  r_phase <= 1'b1;
                end
              end else begin
                r_state     <= S_BREAK;
                r_frame_err <= 1'b1;
                r_phase     <= 1'b0;
              end
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          S_BREAK: begin
            // wait out a held-low line before looking for a new start bit
            if (r_filt) r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign RxD_data_ready = r_data_ready;
  assign RxD_data       = r_data;
  assign RxD_word_ready = r_word_ready;
  assign RxD_word       = r_word;
  assign RxD_frame_err  = r_frame_err;
  assign RxD_idle       = r_idle;

endmodule

// File: tb/tb_uart_rx_word.sv
// Directed bench for uart_rx_word: one tick per clock, 16 clocks per bit.
// Expected bytes/words are queued when a frame is driven and checked when
// the receiver pulses.
`timescale 1ns/1ps
module tb_uart_rx_word;
  localparam int OS   = 16;
  localparam int BAUD = 115200;
  localparam int CLKF = 16 * BAUD;
  localparam int BIT  = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        RxD = 1'b1;
  logic        RxD_data_ready;
  logic [7:0]  RxD_data;
  logic        RxD_word_ready;
  logic [15:0] RxD_word;
  logic        RxD_frame_err;
  logic        RxD_idle;

  int n_cmp = 0;
  int n_fail = 0;
  int n_rdy = 0;
  int n_wrdy = 0;
  int n_ferr = 0;
  logic       prev_rdy = 1'b0;
  logic [7:0]  q_byte[$];
  logic [15:0] q_word[$];
  logic        m_ph = 1'b0;
  logic [7:0]  m_low = 8'h00;

  uart_rx_word #(.ClkFrequency(CLKF), .Baud(BAUD), .Oversampling(OS)) dut (
    .clk(clk), .rst_n(rst_n), .RxD(RxD),
    .RxD_data_ready(RxD_data_ready), .RxD_data(RxD_data),
    .RxD_word_ready(RxD_word_ready), .RxD_word(RxD_word),
    .RxD_frame_err(RxD_frame_err), .RxD_idle(RxD_idle)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic bit_out(input logic v);
    RxD = v;
    clks(BIT);
  endtask

  // Drive one 8N1 frame; a good stop bit queues the byte (and word, if paired)
  task automatic send(input logic [7:0] b, input logic stop);
    if (stop) begin
      q_byte.push_back(b);
      if (m_ph) begin
        q_word.push_back({b, m_low});
        m_ph = 1'b0;
      end else begin
        m_low = b;
        m_ph  = 1'b1;
      end
    end else begin
      m_ph = 1'b0;
    end
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(b[i]);
    bit_out(stop);
    RxD = 1'b1;
  endtask

  initial begin
    #(500000);
    $display("FAIL timeout: observed no end expected end of test");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] partial;
    int wait_n;
    fork
      forever begin
        @(negedge clk);
        if (rst_n) begin
          if (RxD_data_ready) begin
            n_rdy++;
            chk("rdy_width", 32'(prev_rdy), 32'd0);
            chk("byte_expected", 32'(q_byte.size() != 0), 32'd1);
            if (q_byte.size() != 0) chk("byte", 32'(RxD_data), 32'(q_byte.pop_front()));
          end
          if (RxD_word_ready) begin
            n_wrdy++;
            chk("word_with_byte", 32'(RxD_data_ready), 32'd1);
            chk("word_expected", 32'(q_word.size() != 0), 32'd1);
            if (q_word.size() != 0) chk("word", 32'(RxD_word), 32'(q_word.pop_front()));
          end
          if (RxD_frame_err) begin
            n_ferr++;
            chk("ferr_exclusive", 32'(RxD_data_ready | RxD_word_ready), 32'd0);
          end
          prev_rdy = RxD_data_ready;
        end else begin
          prev_rdy = 1'b0;
        end
      end
    join_none

    // reset values
    #1;
    chk("rst_data", 32'(RxD_data), 32'h00);
    chk("rst_word", 32'(RxD_word), 32'h0000);
    chk("rst_rdy", 32'(RxD_data_ready), 32'd0);
    chk("rst_wrdy", 32'(RxD_word_ready), 32'd0);
    chk("rst_ferr", 32'(RxD_frame_err), 32'd0);
    chk("rst_idle", 32'(RxD_idle), 32'd0);
    clks(3);
    rst_n = 1'b1;
    clks(20);

    // two good bytes form one word
    send(8'hA5, 1'b1);
    send(8'h3C, 1'b1);
    clks(40);
    chk("a5_3c_rdy_cnt", 32'(n_rdy), 32'd2);
    chk("a5_3c_wrdy_cnt", 32'(n_wrdy), 32'd1);
    chk("a5_3c_word", 32'(RxD_word), 32'h3CA5);

    // short low glitch is rejected
    RxD = 1'b0;
    clks(6);
    RxD = 1'b1;
    clks(40);
    chk("glitch_rdy_cnt", 32'(n_rdy), 32'd2);
    chk("glitch_ferr_cnt", 32'(n_ferr), 32'd0);
    chk("glitch_data", 32'(RxD_data), 32'h3C);

    // pending low byte, then bad stop bit clears it
    send(8'h99, 1'b1);
    send(8'h55, 1'b0);
    clks(20);
    chk("ferr_cnt", 32'(n_ferr), 32'd1);
    chk("ferr_rdy_cnt", 32'(n_rdy), 32'd3);
    chk("ferr_data_held", 32'(RxD_data), 32'h99);
    send(8'h11, 1'b1);
    send(8'h22, 1'b1);
    clks(40);
    chk("ferr_word", 32'(RxD_word), 32'h2211);
    chk("ferr_wrdy_cnt", 32'(n_wrdy), 32'd2);

    // long idle clears the pending byte
    send(8'h01, 1'b1);
    chk("idle_low_after_byte", 32'(RxD_idle), 32'd0);
    clks(140);
    chk("idle_low_140", 32'(RxD_idle), 32'd0);
    clks(60);
    chk("idle_high_200", 32'(RxD_idle), 32'd1);
    m_ph = 1'b0;
    send(8'h02, 1'b1);
    chk("idle_drop", 32'(RxD_idle), 32'd0);
    chk("idle_no_word", 32'(n_wrdy), 32'd2);
    send(8'h03, 1'b1);
    clks(40);
    chk("idle_word", 32'(RxD_word), 32'h0302);
    chk("idle_wrdy_cnt", 32'(n_wrdy), 32'd3);

    // reset in the middle of bit 4 of 0xF0
    partial = 8'hF0;
    bit_out(1'b0);
    for (int i = 0; i < 4; i++) bit_out(partial[i]);
    RxD = partial[4];
    clks(8);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_data", 32'(RxD_data), 32'h00);
    chk("mid_rst_word", 32'(RxD_word), 32'h0000);
    chk("mid_rst_idle", 32'(RxD_idle), 32'd0);
    chk("mid_rst_pulses", 32'({RxD_data_ready, RxD_word_ready, RxD_frame_err}), 32'd0);
    m_ph = 1'b0;
    RxD = 1'b1;
    clks(5);
    rst_n = 1'b1;
    clks(20);
    send(8'h7E, 1'b1);
    clks(40);
    chk("post_rst_data", 32'(RxD_data), 32'h7E);

    // silence drops the lone 0x7E, then back-to-back frames
    clks(200);
    m_ph = 1'b0;
    chk("idle_before_b2b", 32'(RxD_idle), 32'd1);
    send(8'h00, 1'b1);
    send(8'hFF, 1'b1);
    clks(40);
    chk("b2b_word", 32'(RxD_word), 32'hFF00);
    chk("b2b_data", 32'(RxD_data), 32'hFF);

    // drain with a bounded wait
    wait_n = 0;
    while ((q_byte.size() != 0 || q_word.size() != 0) && wait_n < 200) begin
      clks(1);
      wait_n++;
    end
    chk("drain_bytes", 32'(q_byte.size()), 32'd0);
    chk("drain_words", 32'(q_word.size()), 32'd0);
    chk("total_rdy", 32'(n_rdy), 32'd11);
    chk("total_wrdy", 32'(n_wrdy), 32'd4);
    chk("total_ferr", 32'(n_ferr), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
